// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   XLEN                 - architectural word width
//   *_LSB / *_W / *_BIT  - positions of the pre-sliced decode fields
//   NOP_INSTR            - canonical ADDI x0,x0,0, reserved for decode bubbles
//   fetch_entry_t        - one prefetch FIFO entry (instruction word + its PC)
//   word_align()         - clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN = 32;

  localparam int OPCODE_LSB   = 0;
  localparam int OPCODE_W     = 7;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_W     = 3;
  localparam int FUNCT7_5_BIT = 30;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding instruction words with their PCs.
//   clk, rst     - clock, asynchronous active-high reset
//   push         - write push_entry at the tail (ignored when full or flushing)
//   push_entry   - instruction word + PC to store
//   pop          - remove the head entry (ignored when empty)
//   flush        - empty the FIFO at the next edge; wins over push and pop
//   head         - current head entry (only meaningful when count != 0)
//   count        - number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign push_ok = push && !flush && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // NOTE: the storage array has no reset; nothing reads an entry before it is
  // written because the head is only used while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Holds the fetch PC, issues word reads
// to instruction memory, buffers returned words in a prefetch FIFO and hands
// them to decode together with their PC and pre-sliced decode fields.
//   clk, rst                  - clock, asynchronous active-high reset
//   redirect, redirect_pc     - taken branch and its target (bits [1:0] ignored)
//   imem_req_valid/_ready     - read request handshake
//   imem_addr                 - word-aligned request address
//   imem_rsp_valid/_data      - in-order read responses
//   instr_valid/_ready        - decode handshake on the FIFO head
//   instr, instr_pc           - head instruction and its PC
//   opcode, funct3, funct7_5  - decode fields sliced from instr
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [XLEN-1:0]     imem_rsp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT3_W-1:0] funct3,
  output logic                funct7_5
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,      rsp_pc_d;     // PC of the next kept response
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q,    drop_cnt_d;
  logic            redir_pend_q,  redir_pend_d; // target waiting behind a stale request
  logic [XLEN-1:0] redir_pc_q,    redir_pc_d;

  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_keep;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_push_entry;

  assign target   = word_align(redirect_pc);
  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding cannot belong to this core; ignore it.
  assign rsp_ok   = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep = rsp_ok && (drop_cnt_q == '0) && !redirect;

  // Outstanding plus buffered never exceeds DEPTH, so a kept response always
  // finds room. The sum only falls without an accept, so a raised request
  // stays raised until it is taken.
  assign inflight       = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count);
  assign imem_req_valid = !rst && (inflight < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves a variable unassigned (which would infer a latch).
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    redir_pend_d  = redir_pend_q;
    redir_pc_d    = redir_pc_q;

    unique case ({req_fire, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (rsp_ok && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end

    if (req_fire) begin
      if (redir_pend_q) begin
        // The held request belongs to the old path: drop its response and
        // continue from the deferred branch target.
        fetch_pc_d   = redir_pc_q;
        drop_cnt_d   = drop_cnt_d + CW'(1);
        redir_pend_d = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end

    if (redirect) begin
      // Everything accepted up to and including this cycle is stale.
      drop_cnt_d = outstanding_d;
      rsp_pc_d   = target;
      redir_pc_d = target;
      if (imem_req_valid && !imem_req_ready) begin
        // Request already on the bus cannot be withdrawn; keep its address
        // and switch to the target once it is accepted.
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = 1'b1;
      end else begin
        fetch_pc_d   = target;
        redir_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      redir_pend_q  <= redir_pend_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign fifo_push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .push_entry (fifo_push_entry),
    .pop        (instr_ready),
    .flush      (redirect),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Outputs read as reset values whenever the FIFO is empty.
  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_head.instr : '0;
  assign instr_pc    = instr_valid ? fifo_head.pc    : RESET_PC;
  assign opcode      = instr[OPCODE_LSB +: OPCODE_W];
  assign funct3      = instr[FUNCT3_LSB +: FUNCT3_W];
  assign funct7_5    = instr[FUNCT7_5_BIT];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed, table-driven bench for instr_fetch_unit with a
// one-cycle instruction memory model; plus hand sequences for the held-request
// redirect and mid-stream reset corner cases.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_q[$];

  typedef struct {
    logic        rdr;
    logic [31:0] rdr_pc;
    logic        iready;
    logic        qready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_ivalid;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7_5       (funct7_5)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h4000_1033;
  endfunction

  function automatic vec_t mk(input logic rdr, input logic [31:0] rdr_pc,
                              input logic iready, input logic qready,
                              input logic erv, input logic [31:0] eaddr,
                              input logic eiv, input logic [31:0] eipc);
    vec_t v;
    v.rdr = rdr; v.rdr_pc = rdr_pc; v.iready = iready; v.qready = qready;
    v.exp_req_valid = erv; v.exp_addr = eaddr; v.exp_ivalid = eiv; v.exp_ipc = eipc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks the head against the memory contents expected at exp_pc.
  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    logic [31:0] w;
    w = mem_word(exp_pc);
    check({tag, " instr_pc"}, instr_pc, exp_pc);
    check({tag, " instr"},    instr,    w);
    check({tag, " opcode"},   32'(opcode),   32'(w[6:0]));
    check({tag, " funct3"},   32'(funct3),   32'(w[14:12]));
    check({tag, " funct7_5"}, 32'(funct7_5), 32'(w[30]));
  endtask

  // Called at a negedge with inputs set: drives this cycle's response (for a
  // request accepted in an earlier cycle), records this cycle's accept, then
  // advances to the next negedge.
  task automatic step();
    if (!rst && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (!rst && imem_req_valid && imem_req_ready) mem_q.push_back(imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_q.delete();
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imem_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, " imem_addr"},      imem_addr,            32'h0);
    check({tag, " instr_valid"},    32'(instr_valid),     32'd0);
    check({tag, " instr"},          instr,                32'h0);
    check({tag, " instr_pc"},       instr_pc,             32'h0);
    check({tag, " opcode"},         32'(opcode),          32'd0);
    check({tag, " funct3"},         32'(funct3),          32'd0);
    check({tag, " funct7_5"},       32'(funct7_5),        32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    step(); step();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;

    // ---- table: stream, decode stall, redirect with responses in flight ----
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h14, 1, 32'h08));
    for (int i = 6; i <= 13; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 32'h18, 1, 32'h08));
    vecs.push_back(mk(0, 0, 1, 1, 0, 32'h18, 1, 32'h08));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h18, 1, 32'h0C));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h1C, 1, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h20, 1, 32'h14));
    // redirect together with a response and a pop; target low bits ignored
    vecs.push_back(mk(1, 32'h103, 1, 1, 1, 32'h24, 1, 32'h18));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h104, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h108, 1, 32'h100));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h10C, 1, 32'h104));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("cyc%0d", i);
      redirect       = vecs[i].rdr;
      redirect_pc    = vecs[i].rdr_pc;
      instr_ready    = vecs[i].iready;
      imem_req_ready = vecs[i].qready;
      #1;
      check({tag, " imem_req_valid"}, 32'(imem_req_valid), 32'(vecs[i].exp_req_valid));
      check({tag, " imem_addr"},      imem_addr,            vecs[i].exp_addr);
      check({tag, " instr_valid"},    32'(instr_valid),     32'(vecs[i].exp_ivalid));
      if (vecs[i].exp_ivalid) check_head(tag, vecs[i].exp_ipc);
      step();
    end
    redirect = 1'b0;

    // ---- redirect while request 0x20 is on the bus but not accepted ----
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("held pre addr", imem_addr, 32'h20);
    check("held pre valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    #1;
    check("held addr", imem_addr, 32'h20);
    check("held valid", 32'(imem_req_valid), 32'd1);
    check("held flush", 32'(instr_valid), 32'd0);
    step();
    check("held addr2", imem_addr, 32'h20);
    imem_req_ready = 1'b1;
    step();
    check("target addr", imem_addr, 32'h40);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (instr_valid) begin
        seen = 1'b1;
        check_head("target head", 32'h40);
      end else begin
        step();
      end
    end
    if (!seen) check("target delivered", 32'd0, 32'd1);

    // ---- reset asserted mid-stream with a full FIFO ----
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("full no req", 32'(imem_req_valid), 32'd0);
    check("full head", instr_pc, 32'h0);
    rst = 1'b1;
    mem_q.delete();
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("restart valid", 32'(imem_req_valid), 32'd1);
    check("restart addr",  imem_addr,            32'h0);
    step(); step();
    #1;
    check("restart ivalid", 32'(instr_valid), 32'd1);
    check_head("restart head", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
